// File: rtl/snoop_adapter.sv
// Snooper-side packet writer: claims a ping-pong buffer, stores an AXI-Stream packet big-endian
// from word 0, and reports its byte length to the buffer manager (or drops it when none is free).
module snoop_adapter #(
    parameter int unsigned BYTE_ADDR_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned DATA_WIDTH      = 2 ** (BYTE_ADDR_WIDTH - ADDR_WIDTH) * 8,
    parameter int unsigned PLEN_WIDTH      = 32,
    parameter bit          DROP_WHEN_FULL  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_en,
    input  logic                    rdy,
    output logic                    rdy_ack,
    output logic                    done,
    output logic [PLEN_WIDTH-1:0]   byte_len,
    output logic [15:0]             drop_cnt
);
    localparam int unsigned KeepWidth = DATA_WIDTH / 8;
    localparam int unsigned CntWidth  = $clog2(KeepWidth + 1);
    localparam int unsigned SumWidth  = PLEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] WordOne = 1;

    typedef enum logic [2:0] {StIdle, StClaim, StWrite, StDrop, StFinish} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [PLEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic [PLEN_WIDTH-1:0] byte_len_q, byte_len_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  beat;
    logic [CntWidth-1:0]   add_bytes;
    logic [SumWidth-1:0]   byte_sum;
    logic [PLEN_WIDTH-1:0] byte_sat;

    // Byte 0 sits in the MSB of tkeep, so count ones from the top down.
    function automatic logic [CntWidth-1:0] lead_ones(input logic [KeepWidth-1:0] keep);
        logic [CntWidth-1:0] cnt;
        logic                stop;
        cnt  = '0;
        stop = 1'b0;
        for (int i = KeepWidth - 1; i >= 0; i--) begin
            if (!stop) begin
                if (keep[i]) cnt = cnt + CntWidth'(1);
                else         stop = 1'b1;
            end
        end
        return cnt;
    endfunction

    assign s_tready = (state_q == StWrite) || (state_q == StDrop);
    assign rdy_ack  = (state_q == StClaim);
    assign beat     = s_tvalid && s_tready;

    assign add_bytes = s_tlast ? lead_ones(s_tkeep) : CntWidth'(KeepWidth);
    assign byte_sum  = {1'b0, byte_cnt_q} + SumWidth'(add_bytes);
    assign byte_sat  = byte_sum[PLEN_WIDTH] ? '1 : byte_sum[PLEN_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        byte_len_d = byte_len_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            StIdle: begin
                // Hold off for the done cycle so a finished packet cannot re-claim on stale rdy.
                if (!done_q) begin
                    if (rdy)                             state_d = StClaim;
                    else if (DROP_WHEN_FULL && s_tvalid) state_d = StDrop;
                end
            end
            StClaim: begin
                word_cnt_d = '0;
                byte_cnt_d = '0;
                state_d    = StWrite;
            end
            StWrite: begin
                if (beat) begin
                    // Counter saturates at the buffer depth; later beats are counted but not written.
                    if (!word_cnt_q[ADDR_WIDTH]) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        wr_data_d  = s_tdata;
                        word_cnt_d = word_cnt_q + WordOne;
                    end
                    byte_cnt_d = byte_sat;
                    if (s_tlast) state_d = StFinish;
                end
            end
            StDrop: begin
                if (beat && s_tlast) begin
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d = StIdle;
                end
            end
            StFinish: begin
                done_d     = 1'b1;
                byte_len_d = byte_cnt_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            byte_len_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            byte_len_q <= byte_len_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign byte_len = byte_len_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_snoop_adapter.sv
// Self-checking bench for snoop_adapter: scoreboarded write/done monitor, table of single-beat
// packets, and hand-written sequences for drop, backpressure, overflow, gaps and mid-packet reset.
module tb_snoop_adapter;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [3:0]    s_tkeep;
    logic          s_tvalid, s_tlast, s_tready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, rdy, rdy_ack, done;
    logic [31:0]   byte_len;
    logic [15:0]   drop_cnt;

    logic [DW-1:0] b_tdata;
    logic [3:0]    b_tkeep;
    logic          b_tvalid, b_tlast, b_tready;
    logic [AW-1:0] b_wr_addr;
    logic [DW-1:0] b_wr_data;
    logic          b_wr_en, b_rdy, b_rdy_ack, b_done;
    logic [31:0]   b_byte_len;
    logic [15:0]   b_drop_cnt;

    always #5 clk = ~clk;

    snoop_adapter dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .rdy(rdy), .rdy_ack(rdy_ack), .done(done), .byte_len(byte_len),
        .drop_cnt(drop_cnt)
    );

    snoop_adapter #(.DROP_WHEN_FULL(1'b0)) dut_bp (
        .clk(clk), .rst_n(rst_n), .s_tdata(b_tdata), .s_tkeep(b_tkeep), .s_tvalid(b_tvalid),
        .s_tlast(b_tlast), .s_tready(b_tready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_en(b_wr_en), .rdy(b_rdy), .rdy_ack(b_rdy_ack), .done(b_done), .byte_len(b_byte_len),
        .drop_cnt(b_drop_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  keep;
        logic [31:0] data;
        int unsigned exp_len;
    } vec_t;

    wr_t         wr_q[$];
    logic [31:0] len_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_cnt = 0;
    int          exp_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write and every done pulse must match a queued expectation.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             wr_addr, wr_data);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                end
            end
            if (done) begin
                if (len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got byte_len %0d expected none", byte_len);
                end else begin
                    check("byte_len", 64'(byte_len), 64'(len_q.pop_front()));
                end
            end
            if (rdy_ack) ack_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input bit expect_wr, output bit ok);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (s_tready) begin
                ok = 1'b1;
                if (expect_wr) begin
                    if (exp_idx < DEPTH) wr_q.push_back('{addr: AW'(exp_idx), data: d});
                    exp_idx++;
                end
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got s_tready=0 for 100 cycles expected 1");
        end
    endtask

    task automatic finish_pkt(input logic [31:0] exp_len);
        len_q.push_back(exp_len);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic send_pkt(input int nbeats, input logic [3:0] last_keep, input int max_gap,
                            input logic [31:0] exp_len);
        bit ok;
        exp_idx = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            send_beat($urandom(), (i == nbeats - 1) ? last_keep : 4'hF, (i == nbeats - 1),
                      1'b1, ok);
        end
        finish_pkt(exp_len);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; rdy = 1'b0;
        b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0; b_tkeep = '0; b_rdy = 1'b0;
        wr_q.delete();
        len_q.delete();
        exp_idx = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({s_tready, wr_en, rdy_ack, done}), 64'd0);
        check("reset_data", 64'({wr_addr, wr_data}), 64'd0);
        check("reset_len_drop", 64'({byte_len, drop_cnt}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   ok;
        int   ack0;

        vecs[0] = '{keep: 4'b1111, data: 32'hDEADBEEF, exp_len: 4};
        vecs[1] = '{keep: 4'b1110, data: 32'h01020304, exp_len: 3};
        vecs[2] = '{keep: 4'b1100, data: 32'hA5A55A5A, exp_len: 2};
        vecs[3] = '{keep: 4'b1000, data: 32'h12345678, exp_len: 1};
        vecs[4] = '{keep: 4'b0000, data: 32'hFFFF0000, exp_len: 0};
        vecs[5] = '{keep: 4'b1111, data: 32'h0BADF00D, exp_len: 4};

        apply_reset();

        // Basic 3-beat packet with partial last beat.
        rdy     = 1'b1;
        ack0    = ack_cnt;
        exp_idx = 0;
        send_beat(32'h00112233, 4'hF, 1'b0, 1'b1, ok);
        send_beat(32'h44556677, 4'hF, 1'b0, 1'b1, ok);
        send_beat(32'h8899AABB, 4'b1100, 1'b1, 1'b1, ok);
        finish_pkt(32'd10);
        check("t1_ack_count", 64'(ack_cnt - ack0), 64'd1);

        // Drop with no free buffer; rdy rising mid-drop must be ignored.
        apply_reset();
        ack0 = ack_cnt;
        send_beat(32'hCAFE0001, 4'hF, 1'b0, 1'b0, ok);
        rdy = 1'b1;
        send_beat(32'hCAFE0002, 4'hF, 1'b1, 1'b0, ok);
        rdy = 1'b0;
        check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        repeat (3) @(negedge clk);
        check("t2_drop_cnt_hold", 64'(drop_cnt), 64'd1);
        check("t2_no_ack", 64'(ack_cnt - ack0), 64'd0);

        // Backpressure variant: tready held low until rdy.
        b_tdata  = 32'hCAFEF00D;
        b_tkeep  = 4'hF;
        b_tlast  = 1'b1;
        b_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_tready_low", 64'({b_tready, b_wr_en}), 64'd0);
        end
        b_rdy = 1'b1;
        ok    = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (b_tready) ok = 1'b1;
            else @(negedge clk);
        end
        check("bp_tready_seen", 64'(ok), 64'd1);
        @(negedge clk);
        b_tvalid = 1'b0;
        b_rdy    = 1'b0;
        check("bp_write", 64'({b_wr_en, b_wr_addr, b_wr_data}), {31'd0, 1'b1, 10'd0, 32'hCAFEF00D});
        @(negedge clk);
        check("bp_done", 64'({b_done, b_byte_len}), {31'd0, 1'b1, 32'd4});
        check("bp_drop_cnt", 64'(b_drop_cnt), 64'd0);

        // Overflow: 1026 full beats, only 1024 written, true length reported.
        apply_reset();
        rdy = 1'b1;
        send_pkt(DEPTH + 2, 4'hF, 0, 32'd4104);

        // Random valid gaps.
        apply_reset();
        rdy = 1'b1;
        send_pkt(5, 4'hF, 3, 32'd20);
        send_pkt(5, 4'hF, 3, 32'd20);

        // Reset between beats 2 and 3 of a 4-beat packet.
        apply_reset();
        rdy     = 1'b1;
        exp_idx = 0;
        send_beat(32'h11110000, 4'hF, 1'b0, 1'b1, ok);
        send_beat(32'h22220000, 4'hF, 1'b0, 1'b1, ok);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_async", 64'({wr_en, wr_addr, wr_data, s_tready}), 64'd0);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", 64'({done, drop_cnt}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        ack0 = ack_cnt;
        rdy  = 1'b1;
        send_pkt(2, 4'hF, 0, 32'd8);
        check("mid_rst_fresh_ack", 64'(ack_cnt - ack0), 64'd1);

        // Table of single-beat packets back-to-back with rdy held high.
        apply_reset();
        rdy  = 1'b1;
        ack0 = ack_cnt;
        for (int v = 0; v < 6; v++) begin
            exp_idx = 0;
            send_beat(vecs[v].data, vecs[v].keep, 1'b1, 1'b1, ok);
            finish_pkt(vecs[v].exp_len);
            check("b2b_one_ack", 64'(ack_cnt - ack0), 64'd1);
            ack0 = ack_cnt;
        end
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        check("len_queue_empty", 64'(len_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
